// File: rtl/ft245_pkg.sv
// ft245_pkg: FSM state encodings, served-direction encoding and shared constants.
package ft245_pkg;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_RD        = 3'd1;
    localparam state_t S_WR_SETUP  = 3'd2;
    localparam state_t S_WR_STROBE = 3'd3;
    localparam state_t S_WR_HOLD   = 3'd4;
    localparam state_t S_RECOVER   = 3'd5;
    localparam logic SRV_RX = 1'b0;
    localparam logic SRV_TX = 1'b1;
    localparam int MIN_RECOVER = 3;
    function automatic int cmax(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, resets to all ones (inactive FT245 flags).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ft245_fifo_ctrl.sv
// ft245_fifo_ctrl: FT245 async FIFO strobe sequencer bridging to rx/tx valid-ready byte streams.
module ft245_fifo_ctrl
    import ft245_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int RD_CYCLES      = 4,
    parameter int WR_CYCLES      = 4,
    parameter int SETUP_CYCLES   = 1,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxf_n,
    input  logic             txe_n,
    output logic             rd_n,
    output logic             wr,
    output logic             oe,
    output logic [WIDTH-1:0] data_o,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready
);
    localparam int CW = $clog2(cmax(cmax(RD_CYCLES, WR_CYCLES), cmax(SETUP_CYCLES, RECOVER_CYCLES))) + 1;

    if (RECOVER_CYCLES < MIN_RECOVER) begin : g_recover_chk
        $error("RECOVER_CYCLES shorter than flag synchronizer latency");
    end

    function automatic logic [CW-1:0] ld(input int n);
        return CW'(n - 1);
    endfunction

    logic [1:0] flags_s;
    logic rxf_s, txe_s, rd_ok, wr_ok, grant_rd, grant_wr, done, last;
    state_t state;
    logic [CW-1:0] cnt;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  ({rxf_n, txe_n}),
        .q  (flags_s)
    );

    assign rxf_s    = flags_s[1];
    assign txe_s    = flags_s[0];
    assign rd_ok    = !rxf_s && !rx_valid;
    assign wr_ok    = !txe_s && tx_valid;
    // Round-robin: with both eligible, serve the direction not served last.
    assign grant_rd = state == S_IDLE && rd_ok && (!wr_ok || last == SRV_TX);
    assign grant_wr = state == S_IDLE && wr_ok && (!rd_ok || last == SRV_RX);
    assign tx_ready = grant_wr;
    assign done     = cnt == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            last     <= SRV_TX;
            cnt      <= '0;
            rd_n     <= 1'b1;
            wr       <= 1'b0;
            oe       <= 1'b0;
            data_o   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (!done) cnt <= cnt - 1'b1;
            case (state)
                S_IDLE: begin
                    if (grant_rd) begin
                        state <= S_RD;
                        rd_n  <= 1'b0;
                        cnt   <= ld(RD_CYCLES);
                        last  <= SRV_RX;
                    end else if (grant_wr) begin
                        state  <= S_WR_SETUP;
                        oe     <= 1'b1;
                        data_o <= tx_data;
                        cnt    <= ld(SETUP_CYCLES);
                        last   <= SRV_TX;
                    end
                end
                S_RD: if (done) begin
                    state    <= S_RECOVER;
                    rd_n     <= 1'b1;
                    rx_data  <= data_i;
                    rx_valid <= 1'b1;
                    cnt      <= ld(RECOVER_CYCLES);
                end
                S_WR_SETUP: if (done) begin
                    state <= S_WR_STROBE;
                    wr    <= 1'b1;
                    cnt   <= ld(WR_CYCLES);
                end
                S_WR_STROBE: if (done) begin
                    state <= S_WR_HOLD;
                    wr    <= 1'b0;
                end
                S_WR_HOLD: begin
                    state <= S_RECOVER;
                    oe    <= 1'b0;
                    cnt   <= ld(RECOVER_CYCLES);
                end
                S_RECOVER: if (done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ft245_fifo_ctrl.sv
// tb_ft245_fifo_ctrl: randomized scoreboard bench with an FT245 host model and strobe-timing monitor.
module tb_ft245_fifo_ctrl;
    localparam int RD = 4, WRC = 4, SU = 1, RC = 4;

    logic clk = 0, rst = 1, rxf_n = 1, txe_n = 1, rx_ready = 0, tx_valid = 0;
    logic rd_n, wr, oe, rx_valid, tx_ready;
    logic [7:0] data_o, data_i, rx_data, tx_data = 0, host_head = 0;
    int checks = 0, failures = 0, acc_cnt = 0, acc_seen = 0, n_rd = 0;
    bit mon_en = 1;
    logic [7:0] host_q[$], exp_rx[$], exp_tx[$], tx_src[$];
    int order[$];

    ft245_fifo_ctrl #(.WIDTH(8), .RD_CYCLES(RD), .WR_CYCLES(WRC), .SETUP_CYCLES(SU), .RECOVER_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .rxf_n(rxf_n), .txe_n(txe_n), .rd_n(rd_n), .wr(wr), .oe(oe),
        .data_o(data_o), .data_i(data_i), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;
    assign data_i = rd_n ? 8'hEE : host_head;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Host side of the FT245: the byte at the head is on the bus while RD# is low and leaves on RD# rising.
    bit h_in_rd = 0;
    always @(negedge clk) begin
        if (!rd_n && !rst) h_in_rd = 1;
        else if (rd_n && h_in_rd) begin
            h_in_rd = 0;
            if (host_q.size() != 0) void'(host_q.pop_front());
        end
        rxf_n = host_q.size() == 0;
        host_head = host_q.size() != 0 ? host_q[0] : 8'h00;
    end

    always @(posedge clk) begin
        #1;
        if (acc_cnt != acc_seen) begin
            acc_seen = acc_cnt;
            tx_valid = 0;
        end
        if (!tx_valid && tx_src.size() != 0) begin
            tx_data = tx_src.pop_front();
            tx_valid = 1;
        end
    end

    int rd_w = 0, wr_w = 0, su_w = 0, ho_w = 0, gap = 100, hs = 0;
    bit p_rd = 1, p_wr = 0, p_oe = 0, p_rv = 0, wr_done = 0;
    logic [7:0] rv_data = 0, ev = 0;
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            p_rd = 1; p_wr = 0; p_oe = 0; p_rv = 0; gap = 100; hs = 0; rd_w = 0; wr_w = 0;
        end else begin
            chk(!(oe && !rd_n), "oe_while_rd", int'(oe), 0);
            chk(!wr || oe, "wr_without_oe", int'(oe), 1);
            if (tx_valid && tx_ready) begin
                exp_tx.push_back(tx_data);
                hs++;
                acc_cnt++;
            end
            if (!rd_n && p_rd) begin
                chk(gap >= RC, "gap_before_rd", gap, RC);
                order.push_back(0);
                n_rd++;
            end
            if (oe && !p_oe) begin
                chk(gap >= RC, "gap_before_wr", gap, RC);
                chk(hs == 1, "tx_ready_pulses", hs, 1);
                hs = 0; su_w = 0; ho_w = 0; wr_done = 0;
                order.push_back(1);
            end
            if (rd_n && !p_rd) begin
                chk(rd_w == RD, "rd_width", rd_w, RD);
                chk(rx_valid, "rx_valid_at_rd_end", int'(rx_valid), 1);
                rd_w = 0;
            end
            if (wr && !p_wr) chk(su_w == SU, "setup_cycles", su_w, SU);
            if (!wr && p_wr) begin
                chk(wr_w == WRC, "wr_width", wr_w, WRC);
                wr_w = 0;
                wr_done = 1;
                if (exp_tx.size() == 0) chk(0, "tx_unexpected", int'(data_o), -1);
                else begin
                    ev = exp_tx.pop_front();
                    chk(data_o == ev, "tx_data", int'(data_o), int'(ev));
                end
            end
            if (!oe && p_oe) chk(ho_w == 1, "hold_cycles", ho_w, 1);
            if (rx_valid && !p_rv) begin
                if (exp_rx.size() == 0) chk(0, "rx_unexpected", int'(rx_data), -1);
                else begin
                    ev = exp_rx.pop_front();
                    chk(rx_data == ev, "rx_data", int'(rx_data), int'(ev));
                end
                rv_data = rx_data;
            end else if (rx_valid) chk(rx_data == rv_data, "rx_stable", int'(rx_data), int'(rv_data));
            if (!rd_n) rd_w++;
            if (wr) wr_w++;
            if (oe && !wr) begin
                if (wr_done) ho_w++;
                else su_w++;
            end
            gap = (rd_n && !oe && !wr) ? gap + 1 : 0;
            p_rd = rd_n; p_wr = wr; p_oe = oe; p_rv = rx_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rx(input logic [7:0] b);
        host_q.push_back(b);
        exp_rx.push_back(b);
    endtask

    task automatic drain();
        int n = 0;
        rx_ready = 1;
        txe_n = 0;
        while ((exp_rx.size() != 0 || exp_tx.size() != 0 || tx_src.size() != 0 || tx_valid || host_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        chk(n < 3000, "drain_timeout", n, 3000);
        repeat (10) step();
    endtask

    initial begin
        int n, bad, n0;
        repeat (3) step();
        chk(rd_n == 1 && wr == 0 && oe == 0, "reset_strobes", {29'd0, rd_n, wr, oe}, 4);
        chk(data_o == 0 && rx_data == 0, "reset_data", int'(data_o) + int'(rx_data), 0);
        chk(!rx_valid && !tx_ready, "reset_handshake", int'(rx_valid) + int'(tx_ready), 0);
        rst = 0;
        bad = 0;
        repeat (20) begin
            step();
            if (!rd_n || wr || oe || rx_valid || tx_ready) bad++;
        end
        chk(bad == 0, "idle_hold", bad, 0);

        order.delete();
        for (int i = 0; i < 3; i++) begin
            push_rx(8'($urandom));
            tx_src.push_back(8'($urandom));
        end
        txe_n = 0;
        rx_ready = 1;
        n = 0;
        while (order.size() < 6 && n < 500) begin step(); n++; end
        chk(order.size() >= 6, "contention_count", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++) chk(order[i] == i % 2, "contention_order", order[i], i % 2);
        drain();

        push_rx(8'hA5);
        n = 0;
        while (!rx_valid && n < 50) begin step(); n++; end
        chk(rx_data == 8'hA5, "single_read", int'(rx_data), 8'hA5);
        step();
        chk(!rx_valid, "rx_valid_one_cycle", int'(rx_valid), 0);
        drain();

        tx_src.push_back(8'h3C);
        n = 0;
        while (!wr && n < 50) begin step(); n++; end
        chk(oe && data_o == 8'h3C, "single_write", int'(data_o), 8'h3C);
        drain();

        rx_ready = 0;
        n0 = n_rd;
        push_rx(8'h11);
        push_rx(8'h22);
        repeat (60) step();
        chk(n_rd - n0 == 1, "backpressure_reads", n_rd - n0, 1);
        chk(rx_valid && rx_data == 8'h11, "backpressure_hold", int'(rx_data), 8'h11);
        rx_ready = 1;
        drain();
        chk(n_rd - n0 == 2, "backpressure_resume", n_rd - n0, 2);

        txe_n = 1;
        repeat (4) step();
        tx_src.push_back(8'h5A);
        bad = 0;
        repeat (50) begin
            step();
            if (tx_ready || wr) bad++;
        end
        chk(bad == 0, "tx_blocked", bad, 0);
        txe_n = 0;
        n = 0;
        while (!tx_ready && n < 10) begin step(); n++; end
        chk(n <= 3, "tx_unblock_latency", n, 3);
        drain();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0 && host_q.size() < 3) push_rx(8'($urandom));
            if ($urandom_range(3) == 0 && tx_src.size() < 2) tx_src.push_back(8'($urandom));
            rx_ready = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) txe_n = !txe_n;
            step();
        end
        drain();
        chk(exp_rx.size() == 0, "rx_queue_empty", exp_rx.size(), 0);
        chk(exp_tx.size() == 0, "tx_queue_empty", exp_tx.size(), 0);

        mon_en = 0;
        host_q.push_back(8'h77);
        n = 0;
        while (rd_n && n < 50) begin step(); n++; end
        chk(!rd_n, "rd_start_before_reset", int'(rd_n), 0);
        step();
        #2;
        rst = 1;
        #1;
        chk(rd_n, "rd_n_async_reset", int'(rd_n), 1);
        chk(!oe && !wr && !rx_valid, "outputs_async_reset", int'(oe) + int'(wr) + int'(rx_valid), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
